// File: rtl/fwft_fifo_pkg.sv
// Shared helpers for the first-word-fall-through FIFO.
// Holds the rule for which DEPTH values the FIFO supports.
package fwft_fifo_pkg;

    function automatic bit depth_legal(input int depth);
        return (depth == 1) || (depth == 2);
    endfunction

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, 1 or 2 entries.
// Outputs come only from registers; a_ready also looks at b_ready, so a full FIFO can take a write while it is popped.
module fwft_fifo
    import fwft_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
);

    logic push;
    logic pop;

    generate
        if (!depth_legal(DEPTH)) begin : g_bad_depth
            $error("fwft_fifo: DEPTH must be 1 or 2");
        end else if (DEPTH == 1) begin : g_depth1
            logic [WIDTH-1:0] data_q, data_d;
            logic             full_q, full_d;

            assign a_ready = !full_q || b_ready;
            assign b_valid = full_q;
            assign b_data  = data_q;
            assign push    = a_valid && a_ready;
            assign pop     = full_q && b_ready;

            // A push while full is only possible together with a pop, so it replaces the entry.
            always_comb begin
                data_d = data_q;
                full_d = full_q;
                if (push) begin
                    data_d = a_data;
                    full_d = 1'b1;
                end else if (pop) begin
                    full_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    full_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    full_q <= full_d;
                end
            end
        end else begin : g_depth2
            logic [WIDTH-1:0] mem_q [2];
            logic [WIDTH-1:0] mem_d [2];
            logic             rd_ptr_q, rd_ptr_d;
            logic             wr_ptr_q, wr_ptr_d;
            logic [1:0]       count_q, count_d;

            assign a_ready = (count_q < 2'd2) || b_ready;
            assign b_valid = (count_q != 2'd0);
            assign b_data  = mem_q[rd_ptr_q];
            assign push    = a_valid && a_ready;
            assign pop     = b_valid && b_ready;

            // When full, wr_ptr == rd_ptr: a push+pop overwrites the head being consumed.
            always_comb begin
                mem_d    = mem_q;
                rd_ptr_d = rd_ptr_q;
                wr_ptr_d = wr_ptr_q;
                count_d  = count_q;
                if (push) begin
                    mem_d[wr_ptr_q] = a_data;
                    wr_ptr_d        = !wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_d = !rd_ptr_q;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 2'd1;
                    2'b01:   count_d = count_q - 2'd1;
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[0] <= '0;
                    mem_q[1] <= '0;
                    rd_ptr_q <= 1'b0;
                    wr_ptr_q <= 1'b0;
                    count_q  <= 2'd0;
                end else begin
                    mem_q    <= mem_d;
                    rd_ptr_q <= rd_ptr_d;
                    wr_ptr_q <= wr_ptr_d;
                    count_q  <= count_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fwft_fifo.sv
// Bench for fwft_fifo: a 2-deep and a 1-deep instance, each with a queue scoreboard and a negedge monitor.
// Directed checks use hand-computed constants; the monitor also checks every pop against the queue.
module tb_fwft_fifo;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a_data2 = '0, b_data2;
    logic         a_valid2 = 1'b0, a_ready2, b_valid2, b_ready2 = 1'b0;
    logic [W-1:0] a_data1 = '0, b_data1;
    logic         a_valid1 = 1'b0, a_ready1, b_valid1, b_ready1 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int pops2  = 0;
    int pops1  = 0;
    logic [W-1:0] q2[$];
    logic [W-1:0] q1[$];

    always #5 clk = ~clk;

    fwft_fifo #(.WIDTH(W), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_data(a_data2), .a_valid(a_valid2), .a_ready(a_ready2),
        .b_data(b_data2), .b_valid(b_valid2), .b_ready(b_ready2)
    );

    fwft_fifo #(.WIDTH(W), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_data(a_data1), .a_valid(a_valid1), .a_ready(a_ready1),
        .b_data(b_data1), .b_valid(b_valid1), .b_ready(b_ready1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs are stable between negedge and the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
            q1.delete();
        end else begin
            int  sz;
            bit  acc;
            sz  = q2.size();
            acc = a_valid2 && ((sz < 2) || b_ready2);
            chk("sb_b_valid2", {31'd0, b_valid2}, {31'd0, sz != 0});
            chk("sb_a_ready2", {31'd0, a_ready2}, {31'd0, (sz < 2) || b_ready2});
            if (sz != 0 && b_ready2) begin
                chk("sb_b_data2", {16'd0, b_data2}, {16'd0, q2.pop_front()});
                pops2++;
            end
            if (acc) q2.push_back(a_data2);

            sz  = q1.size();
            acc = a_valid1 && ((sz < 1) || b_ready1);
            chk("sb_b_valid1", {31'd0, b_valid1}, {31'd0, sz != 0});
            chk("sb_a_ready1", {31'd0, a_ready1}, {31'd0, (sz < 1) || b_ready1});
            if (sz != 0 && b_ready1) begin
                chk("sb_b_data1", {16'd0, b_data1}, {16'd0, q1.pop_front()});
                pops1++;
            end
            if (acc) q1.push_back(a_data1);
        end
    end

    initial begin
        int p0;
        // Reset held two cycles with writes pending
        rst = 1'b1; a_valid2 = 1'b1; a_data2 = 16'h0077; a_valid1 = 1'b1; a_data1 = 16'h0066;
        tick(); tick();
        rst = 1'b0; a_valid2 = 1'b0; a_valid1 = 1'b0;
        #1;
        chk("rst_b_valid2", {31'd0, b_valid2}, 32'd0);
        chk("rst_a_ready2", {31'd0, a_ready2}, 32'd1);
        chk("rst_b_data2", {16'd0, b_data2}, 32'd0);
        chk("rst_b_valid1", {31'd0, b_valid1}, 32'd0);
        chk("rst_a_ready1", {31'd0, a_ready1}, 32'd1);
        chk("rst_b_data1", {16'd0, b_data1}, 32'd0);
        tick();
        chk("rst_still_empty2", {31'd0, b_valid2}, 32'd0);

        // Single transfer, DEPTH=2
        a_data2 = 16'h00A5; a_valid2 = 1'b1; b_ready2 = 1'b0;
        tick();
        a_valid2 = 1'b0;
        chk("single_valid", {31'd0, b_valid2}, 32'd1);
        chk("single_data", {16'd0, b_data2}, 32'h00A5);
        b_ready2 = 1'b1;
        tick();
        b_ready2 = 1'b0;
        chk("single_drained", {31'd0, b_valid2}, 32'd0);

        // Fill and order, DEPTH=2: third write dropped
        a_valid2 = 1'b1; a_data2 = 16'd1; tick();
        a_data2 = 16'd2; tick();
        a_data2 = 16'd3; #1;
        chk("fill_a_ready_low", {31'd0, a_ready2}, 32'd0);
        tick();
        a_valid2 = 1'b0;
        chk("fill_head1", {16'd0, b_data2}, 32'd1);
        b_ready2 = 1'b1;
        tick();
        chk("fill_head2", {16'd0, b_data2}, 32'd2);
        chk("fill_valid2", {31'd0, b_valid2}, 32'd1);
        tick();
        b_ready2 = 1'b0;
        chk("fill_empty", {31'd0, b_valid2}, 32'd0);

        // Full DEPTH=1 with simultaneous push and pop
        a_data1 = 16'h0010; a_valid1 = 1'b1; b_ready1 = 1'b0;
        tick();
        chk("d1_full_data", {16'd0, b_data1}, 32'h0010);
        chk("d1_full_a_ready", {31'd0, a_ready1}, 32'd0);
        a_data1 = 16'h0020; b_ready1 = 1'b1;
        #1;
        chk("d1_pushpop_a_ready", {31'd0, a_ready1}, 32'd1);
        tick();
        a_valid1 = 1'b0; b_ready1 = 1'b0;
        chk("d1_pushpop_data", {16'd0, b_data1}, 32'h0020);
        chk("d1_pushpop_valid", {31'd0, b_valid1}, 32'd1);
        b_ready1 = 1'b1; tick(); b_ready1 = 1'b0;
        chk("d1_empty", {31'd0, b_valid1}, 32'd0);

        // Streaming 0..99, DEPTH=2
        p0 = pops2;
        b_ready2 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_data2 = 16'(i); a_valid2 = 1'b1;
            tick();
            chk("stream_latency", {16'd0, b_data2}, i);
        end
        a_valid2 = 1'b0;
        tick(); tick();
        b_ready2 = 1'b0;
        chk("stream_count", pops2 - p0, 32'd100);

        // Random back-pressure on both depths
        for (int c = 0; c < 10000; c++) begin
            a_valid2 = 1'($urandom_range(0, 1)); b_ready2 = 1'($urandom_range(0, 1));
            a_data2  = 16'($urandom);
            a_valid1 = 1'($urandom_range(0, 1)); b_ready1 = 1'($urandom_range(0, 1));
            a_data1  = 16'($urandom);
            tick();
        end

        // Reset mid-operation discards contents
        a_valid2 = 1'b1; a_data2 = 16'h0055; b_ready2 = 1'b0;
        a_valid1 = 1'b1; a_data1 = 16'h0044; b_ready1 = 1'b0;
        tick();
        rst = 1'b1; a_valid2 = 1'b0; a_valid1 = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_b_valid2", {31'd0, b_valid2}, 32'd0);
        chk("midrst_b_valid1", {31'd0, b_valid1}, 32'd0);
        chk("midrst_a_ready2", {31'd0, a_ready2}, 32'd1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
